// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall/flush vectors, PC redirect handshake,
// wait watchdog and stall/flush event counters. stall/flush/redirect are combinational; state and counters are registered.
module pipe_ctrl #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_re,
  input  logic [4:0]       id_reg1_raddr,
  input  logic             id_reg2_re,
  input  logic [4:0]       id_reg2_raddr,
  input  logic             ex_we,
  input  logic [4:0]       ex_waddr,
  input  logic             ex_is_load,
  input  logic             ex_busy,
  input  logic             mem_busy,
  input  logic             ex_jump_req,
  input  logic [31:0]      ex_jump_addr,
  output logic             redirect_valid,
  output logic [31:0]      redirect_addr,
  input  logic             redirect_ready,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, EX_WAIT, MEM_WAIT, REDIR_HOLD} state_t;

  localparam int WC_W = ($clog2(WAIT_LIMIT + 1) < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0]  stall_c, flush_c;
  logic        rv_c, accept, load_use, in_wait;
  logic [31:0] raddr_c;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign load_use = ex_we & ex_is_load & (ex_waddr != 5'd0) &
                    ((id_reg1_re & (id_reg1_raddr == ex_waddr)) |
                     (id_reg2_re & (id_reg2_raddr == ex_waddr)));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stall_c = 5'b00000;
    flush_c = 5'b00000;
    rv_c    = 1'b0;
    raddr_c = addr_q;
    accept  = 1'b0;
    if (mem_busy) begin
      stall_c = 5'b01111;
      flush_c = 5'b10000;
      state_d = MEM_WAIT;
    end else if (ex_busy) begin
      stall_c = 5'b00111;
      flush_c = 5'b01000;
      state_d = EX_WAIT;
    end else if (state_q == REDIR_HOLD) begin
      rv_c    = 1'b1;
      stall_c = 5'b00001;
      flush_c = 5'b00010;
      if (redirect_ready) begin
        accept  = 1'b1;
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
      // A jump flushes the dependent ID instruction, so it outranks load-use.
      if (ex_jump_req) begin
        rv_c    = 1'b1;
        raddr_c = ex_jump_addr;
        addr_d  = ex_jump_addr;
        flush_c = 5'b00110;
        if (redirect_ready) begin
          accept = 1'b1;
        end else begin
          state_d = REDIR_HOLD;
        end
      end else if (load_use) begin
        stall_c = 5'b00011;
        flush_c = 5'b00100;
      end
    end
  end

  always_comb begin
    in_wait = (state_q == EX_WAIT) || (state_q == MEM_WAIT);
    wait_d  = '0;
    err_d   = err_q;
    if (in_wait) begin
      wait_d = (wait_q == WC_W'(WAIT_LIMIT)) ? wait_q : wait_q + 1'b1;
      if (wait_q >= WC_W'(WAIT_LIMIT - 1)) begin
        err_d = 1'b1;
      end
    end
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_c[0]);
    flush_cnt_d = flush_cnt_q + CNT_W'(accept);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      addr_q      <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall          = {5{rst}} & stall_c;
  assign flush          = {5{rst}} & flush_c;
  assign redirect_valid = rst & rv_c;
  assign redirect_addr  = rst ? raddr_c : 32'd0;
  assign err_timeout    = err_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_reg1_re = 1'b0, id_reg2_re = 1'b0;
  logic [4:0]  id_reg1_raddr = '0, id_reg2_raddr = '0, ex_waddr = '0;
  logic        ex_we = 1'b0, ex_is_load = 1'b0, ex_busy = 1'b0, mem_busy = 1'b0;
  logic        ex_jump_req = 1'b0, redirect_ready = 1'b0;
  logic [31:0] ex_jump_addr = '0;
  logic        redirect_valid, err_timeout;
  logic [31:0] redirect_addr, stall_cnt, flush_cnt;
  logic [4:0]  stall, flush;

  pipe_ctrl #(.WAIT_LIMIT(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_re(id_reg1_re), .id_reg1_raddr(id_reg1_raddr),
    .id_reg2_re(id_reg2_re), .id_reg2_raddr(id_reg2_raddr),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_is_load(ex_is_load),
    .ex_busy(ex_busy), .mem_busy(mem_busy),
    .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .redirect_ready(redirect_ready),
    .stall(stall), .flush(flush), .err_timeout(err_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        rv;
    logic [31:0] addr;
    logic        chk_addr;
    logic        err;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc_no = 0;
  logic [31:0] exp_scnt = 0;
  logic [31:0] exp_fcnt = 0;

  task automatic chk(input int cyc, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cyc%0d %s got=0x%0h exp=0x%0h", cyc, name, act, exp);
    end
  endtask

  // Monitor: one expectation is consumed per cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.cyc, "stall", {27'd0, stall}, {27'd0, e.stall});
        chk(e.cyc, "flush", {27'd0, flush}, {27'd0, e.flush});
        chk(e.cyc, "redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
        if (e.chk_addr) chk(e.cyc, "redirect_addr", redirect_addr, e.addr);
        chk(e.cyc, "err_timeout", {31'd0, err_timeout}, {31'd0, e.err});
        chk(e.cyc, "stall_cnt", stall_cnt, e.scnt);
        chk(e.cyc, "flush_cnt", flush_cnt, e.fcnt);
      end
    end
  end

  // lu: 0 none, 1 load-use on rs2=x5, 2 load to x0, 3 load-use on rs1=x7, 4 rs1 match but not read
  task automatic cyc(input logic r, input int lu, input logic memb, input logic exb,
                     input logic jreq, input logic [31:0] ja, input logic rdy,
                     input logic [4:0] es, input logic [4:0] ef, input logic erv,
                     input logic [31:0] ea, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    mem_busy       = memb;
    ex_busy        = exb;
    ex_jump_req    = jreq;
    ex_jump_addr   = ja;
    redirect_ready = rdy;
    ex_we          = (lu != 0);
    ex_is_load     = (lu != 0);
    ex_waddr       = (lu == 1) ? 5'd5 : (lu == 3 || lu == 4) ? 5'd7 : 5'd0;
    id_reg1_re     = (lu == 3);
    id_reg1_raddr  = (lu == 3 || lu == 4) ? 5'd7 : 5'd0;
    id_reg2_re     = (lu == 1 || lu == 2);
    id_reg2_raddr  = (lu == 1) ? 5'd5 : 5'd0;
    if (!r) begin
      exp_scnt = 0;
      exp_fcnt = 0;
    end
    e.cyc = cyc_no; e.stall = es; e.flush = ef; e.rv = erv; e.addr = ea;
    e.chk_addr = erv | ~r; e.err = eerr; e.scnt = exp_scnt; e.fcnt = exp_fcnt;
    sb.push_back(e);
    if (r) begin
      if (es[0]) exp_scnt++;
      if (erv && rdy) exp_fcnt++;
    end
    cyc_no++;
  endtask

  initial begin
    //   r lu mb eb jr addr     rdy stall     flush     rv addr     err
    cyc(0, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   0);
    cyc(1, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   0);
    cyc(1, 1, 0, 0, 0, 32'h0,   0, 5'b00011, 5'b00100, 0, 32'h0,   0);
    cyc(1, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   0);
    cyc(1, 2, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   0);
    cyc(1, 3, 0, 0, 0, 32'h0,   0, 5'b00011, 5'b00100, 0, 32'h0,   0);
    cyc(1, 4, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   0);
    cyc(1, 0, 0, 0, 1, 32'h80,  1, 5'b00000, 5'b00110, 1, 32'h80,  0);
    cyc(1, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   0);
    cyc(1, 1, 0, 0, 1, 32'h40,  1, 5'b00000, 5'b00110, 1, 32'h40,  0);
    // redirect held off, target changes underneath
    cyc(1, 0, 0, 0, 1, 32'h100, 0, 5'b00000, 5'b00110, 1, 32'h100, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 1, 32'h200, 0, 5'b00001, 5'b00010, 1, 32'h100, 0);
    cyc(1, 0, 0, 0, 1, 32'h200, 1, 5'b00001, 5'b00010, 1, 32'h100, 0);
    cyc(1, 0, 0, 0, 1, 32'h200, 1, 5'b00000, 5'b00110, 1, 32'h200, 0);
    // ex_busy masks the jump; third wait-state cycle trips the watchdog
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, 1, 1, 32'h300, 1, 5'b00111, 5'b01000, 0, 32'h0, 0);
    cyc(1, 0, 0, 0, 1, 32'h300, 1, 5'b00000, 5'b00110, 1, 32'h300, 1);
    cyc(1, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   1);
    // asynchronous reset while holding a redirect
    cyc(1, 0, 0, 0, 1, 32'h500, 0, 5'b00000, 5'b00110, 1, 32'h500, 1);
    cyc(1, 0, 0, 0, 0, 32'h0,   0, 5'b00001, 5'b00010, 1, 32'h500, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   0);
    cyc(1, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   0);
    // mem_busy over ex_busy, then watchdog from MEM_WAIT
    cyc(1, 0, 1, 1, 0, 32'h0,   0, 5'b01111, 5'b10000, 0, 32'h0,   0);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 1, 0, 0, 32'h0, 0, 5'b01111, 5'b10000, 0, 32'h0,   0);
    cyc(1, 0, 1, 0, 0, 32'h0,   0, 5'b01111, 5'b10000, 0, 32'h0,   1);
    cyc(1, 1, 0, 0, 0, 32'h0,   0, 5'b00011, 5'b00100, 0, 32'h0,   1);
    cyc(1, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   1);
    cyc(1, 0, 1, 0, 1, 32'h600, 1, 5'b01111, 5'b10000, 0, 32'h0,   1);
    cyc(1, 0, 0, 0, 0, 32'h0,   0, 5'b00000, 5'b00000, 0, 32'h0,   1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
